// File: rtl/memory_pkg.sv
// Shared types and helpers for the dual-port memory bank.
package memory_pkg;

    typedef enum logic {
        MEM_CLEAR,
        MEM_READY
    } mem_state_e;

    localparam int RDW_READ_OLD    = 0;
    localparam int RDW_WRITE_FIRST = 1;

    function automatic logic [7:0] merge_bytes(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/memory_rd_pipe.sv
// Read-data pipeline: RD_LAT-deep valid/data shift register, flushed on reset.
module memory_rd_pipe #(
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] data_q [RD_LAT];
    logic [RD_LAT-1:0] valid_q;

    // Data stages only advance with a valid beat, so the output holds between results.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            valid_q[0] <= i_valid;
            if (i_valid) begin
                data_q[0] <= i_data;
            end
            for (int s = 1; s < RD_LAT; s++) begin
                valid_q[s] <= valid_q[s-1];
                if (valid_q[s-1]) begin
                    data_q[s] <= data_q[s-1];
                end
            end
        end
    end

    assign o_valid = valid_q[RD_LAT-1];
    assign o_data  = data_q[RD_LAT-1];

endmodule

// File: rtl/memory_dp_param.sv
// Simple dual-port RAM with byte enables, configurable read latency,
// read-during-write selection and a post-reset clear sequencer.
module memory_dp_param
    import memory_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 4,
    parameter int RD_LAT       = 1,
    parameter int RDW_MODE     = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wr_en,
    input  logic [ADDR_W-1:0]   i_wr_addr,
    input  logic [DATA_W-1:0]   i_data_in,
    input  logic [DATA_W/8-1:0] i_byte_en,
    input  logic                i_rd_en,
    input  logic [ADDR_W-1:0]   i_rd_addr,
    output logic [DATA_W-1:0]   o_data_out,
    output logic                o_valid,
    output logic                o_ready
);

    localparam int DEPTH      = 2 ** ADDR_W;
    localparam int NUM_BYTES  = DATA_W / 8;
    localparam bit WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
        $error("memory_dp_param: DATA_W must be a positive multiple of 8");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("memory_dp_param: RD_LAT must be 1 or 2");
    end
    if (RDW_MODE != RDW_READ_OLD && RDW_MODE != RDW_WRITE_FIRST) begin : g_bad_rdw
        $error("memory_dp_param: RDW_MODE must be 0 or 1");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    mem_state_e        state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] wr_old, wr_word, rd_old, rd_word;

    assign o_ready = (state == MEM_READY);
    assign wr_acc  = o_ready & i_wr_en;
    assign rd_acc  = o_ready & i_rd_en;
    assign wr_old  = mem[i_wr_addr];
    assign rd_old  = mem[i_rd_addr];

    for (genvar b = 0; b < NUM_BYTES; b++) begin : g_merge
        assign wr_word[8*b +: 8] = merge_bytes(wr_old[8*b +: 8], i_data_in[8*b +: 8], i_byte_en[b]);
    end

    // On a same-address collision wr_word is exactly the merged result of this write.
    assign rd_word = (WRITE_FIRST && wr_acc && (i_wr_addr == i_rd_addr)) ? wr_word : rd_old;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= (CLEAR_ON_RST != 0) ? MEM_CLEAR : MEM_READY;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == MEM_CLEAR && cnt != ADDR_W'(DEPTH - 1)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == MEM_CLEAR && cnt == ADDR_W'(DEPTH - 1)) begin
            state_nxt = MEM_READY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (state == MEM_CLEAR) begin
                mem[cnt] <= '0;
            end else if (wr_acc) begin
                mem[i_wr_addr] <= wr_word;
            end
        end
    end

    memory_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (rd_acc),
        .i_data  (rd_word),
        .o_valid (o_valid),
        .o_data  (o_data_out)
    );

endmodule
